run_controller: RTL and testbench
=================================

# run_controller

Synthesizable run controller that sequences a `computer`-class system through reset, execution and halt. It replaces a fixed free-running harness with parametrised reset length and cycle budget, free-run and single-step modes, multi-source halt probes and a readable halt cause. It sits between the clock/reset source and the system under control and drives that system's reset and clock-enable.

## Interface

Parameters:
- `RESET_CYCLES`, default 16: enabled cycles for which `sys_rst_n` is held low after `start`; ≥1.
- `MAX_CYCLES`, default 100000: cycle budget in RUN; 0 disables the timeout.
- `CNT_W`, default 32: width of the cycle counter; must hold `MAX_CYCLES`.
- `N_PROBES`, default 4: number of halt-probe inputs; ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: level; begins a run from IDLE or HALT.
- `step_mode`  in  1: 1 selects single-step, 0 selects free-run; sampled every cycle.
- `step`  in  1: single-step request; each rising edge grants one enabled cycle.
- `abort`  in  1: level; forces a halt.
- `probe`  in  `N_PROBES`: halt requests from the controlled system (trap, done and similar).
- `sys_rst_n`  out  1: reset to the controlled system; registered.
- `clk_en`  out  1: clock enable to the controlled system; registered.
- `running`  out  1: high in RUN.
- `halted`  out  1: high in HALT.
- `halt_code`  out  2: 0 none, 1 timeout, 2 probe, 3 abort.
- `halt_probe`  out  `$clog2(N_PROBES)` (min 1): index of the probe that caused the halt.
- `cycle_count`  out  `CNT_W`: number of enabled RUN cycles since the last `start`.

## Operation

The controller has four states:
- **IDLE**: the state under `rst_n` low.
  - Outputs: `sys_rst_n`=0, `clk_en`=0, `running`=0, `halted`=0, `halt_code`=0, `halt_probe`=0, `cycle_count`=0.
  - `start` moves to HOLD. `abort` is ignored.
- **HOLD**:
  - Outputs: `sys_rst_n`=0, `clk_en`=1. `step_mode` is ignored.
  - The hold counter counts `RESET_CYCLES` cycles, then the controller moves to RUN with `sys_rst_n`=1.
  - `abort` moves to HALT with code 3.
- **RUN**:
  - `clk_en` is 1 in free-run. In step mode it is one pulse per `step` rising edge.
  - `cycle_count` increments on every edge at which `clk_en` is 1. It saturates at all-ones.
  - Halt checks run at every RUN edge, priority abort > probe > timeout.
  - Probe: any `probe` bit high. The lowest set index is latched into `halt_probe`.
  - Timeout: an enabled edge at which `cycle_count == MAX_CYCLES-1`, with `MAX_CYCLES` ≠ 0.
- **HALT**:
  - Outputs: `clk_en`=0. `sys_rst_n` holds its value so the controlled system's state stays inspectable.
  - `halt_code`, `halt_probe` and `cycle_count` are frozen.
  - `start` moves to HOLD, clearing `cycle_count`, `halt_code` and `halt_probe`.

Ignored inputs:
- `start` in HOLD or RUN.
- `step` outside RUN.
- `probe` outside RUN.

Step-edge tracking:
- The `step` edge detector's history register updates in every state.
- A `step` held high yields exactly one enable.
- A step request arriving on the edge that enters RUN is honoured.

## Timing

- **Start**: `start` high at edge k gives `clk_en`=1 and `sys_rst_n`=0 after edge k. `sys_rst_n` rises after edge k+`RESET_CYCLES`.
- **Free-run timeout**: the controlled system receives exactly `MAX_CYCLES` enabled cycles with `sys_rst_n`=1. `clk_en` falls after the edge at which `cycle_count` becomes `MAX_CYCLES`, and `halted` rises on that same edge.
- **Probe halt**: a probe high at RUN edge t sets `halted`=1 and `clk_en`=0 after t. If `clk_en` was 1 during t, that cycle is counted.
- **Step mode**: a `step` rising edge sampled at edge t gives `clk_en`=1 for the single cycle after t.
- **Simultaneous events**:
  - `abort` together with a probe gives code 3.
  - A probe together with timeout gives code 2.
  - `start` together with `abort` in HALT: `start` wins and the controller enters HOLD.
- **Reset mid-operation**: `rst_n` low from any state immediately forces the IDLE outputs (asynchronous), including `sys_rst_n`=0.
- Latency from any halt condition to `clk_en`=0 is exactly one edge.

## Structure

- Package `run_ctrl_pkg`:
  - State enum `run_state_t` (IDLE, HOLD, RUN, HALT).
  - Halt-code constants `HALT_NONE`, `HALT_TIMEOUT`, `HALT_PROBE`, `HALT_ABORT`.
- Sub-module `step_edge`: a registered rising-edge detector on `step`, on the same clock and reset.
- Priority encoder for `probe`: a function in the package.

## Test plan

Bench parameters: `RESET_CYCLES`=4, `MAX_CYCLES`=10, `N_PROBES`=4.

1. Reset then `start` pulse at edge 0 → `sys_rst_n` low for 4 cycles, then 10 enabled cycles → `halted`=1, `halt_code`=1, `cycle_count`=10, `clk_en`=0.
2. Free-run; `probe`=4'b0110 at the 5th RUN edge → `halt_code`=2, `halt_probe`=1, `cycle_count`=5.
3. `step_mode`=1, three `step` pulses (one held high for 3 cycles) → exactly three `clk_en` pulses, `cycle_count`=3, still `running`.
4. `abort` and `probe[3]` on the same edge in RUN → `halt_code`=3. Then `start` → HOLD, `cycle_count`=0, `halt_code`=0.
5. `rst_n` low mid-RUN at `cycle_count`=6 → immediately `sys_rst_n`=0, `clk_en`=0, `cycle_count`=0, IDLE; `probe` then ignored until `start`.
6. `MAX_CYCLES`=0 build, 1000 cycles free-run → no halt, `cycle_count`=1000.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
//   Shared types and helpers for the run controller.
//   - run_state_t : controller state (IDLE, HOLD, RUN, HALT)
//   - HALT_*      : values reported on halt_code
//   - lowest_probe: priority encoder, lowest set request bit wins
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } run_state_t;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_TIMEOUT = 2'd1;
  localparam logic [1:0] HALT_PROBE   = 2'd2;
  localparam logic [1:0] HALT_ABORT   = 2'd3;

  // Widest probe vector the encoder handles; callers zero-extend into it,
  // so the controller supports up to 32 probe inputs.
  localparam int PROBE_MAX = 32;

  // Scanning from the top down leaves the lowest set index in idx.
  function automatic logic [4:0] lowest_probe(input logic [PROBE_MAX-1:0] req);
    logic [4:0] idx;
    idx = '0;
    for (int i = PROBE_MAX - 1; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/run_controller_step_edge.sv
// step_edge
//   Rising-edge detector for the single-step request.
//   clk, rst_n : system clock, asynchronous active-low reset
//   step       : raw step request level
//   rise       : high while step is high and was low at the previous edge
//   The history register updates every cycle regardless of controller
//   state, so a step held high produces exactly one rise.
module step_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic rise
);

  logic step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign rise = step & ~step_q;

endmodule

// File: rtl/run_controller.sv
// run_controller
//   Sequences a controlled system through reset hold, execution and halt,
//   driving its reset and clock enable.
//   Parameters: RESET_CYCLES (hold length), MAX_CYCLES (0 = no timeout),
//               CNT_W (cycle counter width), N_PROBES (halt probes, <= 32)
//   Inputs : clk, rst_n, start, step_mode, step, abort, probe[N_PROBES]
//   Outputs: sys_rst_n, clk_en (registered), running, halted,
//            halt_code (0 none/1 timeout/2 probe/3 abort), halt_probe,
//            cycle_count (enabled RUN cycles since the last start)
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 16,
  parameter int MAX_CYCLES   = 100000,
  parameter int CNT_W        = 32,
  parameter int N_PROBES     = 4,
  localparam int PW          = (N_PROBES > 1) ? $clog2(N_PROBES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                step_mode,
  input  logic                step,
  input  logic                abort,
  input  logic [N_PROBES-1:0] probe,
  output logic                sys_rst_n,
  output logic                clk_en,
  output logic                running,
  output logic                halted,
  output logic [1:0]          halt_code,
  output logic [PW-1:0]       halt_probe,
  output logic [CNT_W-1:0]    cycle_count
);

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam bit TIMEOUT_EN = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = TIMEOUT_EN ? CNT_W'(MAX_CYCLES - 1) : '0;

  run_state_t           state;
  logic [HW-1:0]        hold_cnt;
  logic                 step_rise;
  logic [PROBE_MAX-1:0] probe_ext;
  logic                 timeout_hit;

  step_edge u_step_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .rise  (step_rise)
  );

  assign probe_ext = PROBE_MAX'(probe);

  // clk_en is the registered enable the system saw during the cycle now
  // ending, so it doubles as "this RUN edge is an enabled edge".
  assign timeout_hit = TIMEOUT_EN && clk_en && (cycle_count == TIMEOUT_AT);

  assign running = (state == RUN);
  assign halted  = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      sys_rst_n   <= 1'b0;
      clk_en      <= 1'b0;
      halt_code   <= HALT_NONE;
      halt_probe  <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            sys_rst_n   <= 1'b0;
            clk_en      <= 1'b1;
            cycle_count <= '0;
          end
        end

        HOLD: begin
          if (abort) begin
            state     <= HALT;
            clk_en    <= 1'b0;
            halt_code <= HALT_ABORT;
          end else if (hold_cnt == HOLD_LAST) begin
            // First RUN cycle already honours step mode, so a step edge
            // landing on this transition edge is not lost.
            state     <= RUN;
            sys_rst_n <= 1'b1;
            clk_en    <= step_mode ? step_rise : 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RUN: begin
          // The cycle that just ended is counted even if this edge halts.
          if (clk_en && (cycle_count != '1)) cycle_count <= cycle_count + 1'b1;
          if (abort) begin
            state     <= HALT;
            clk_en    <= 1'b0;
            halt_code <= HALT_ABORT;
          end else if (|probe) begin
            state      <= HALT;
            clk_en     <= 1'b0;
            halt_code  <= HALT_PROBE;
            halt_probe <= PW'(lowest_probe(probe_ext));
          end else if (timeout_hit) begin
            state     <= HALT;
            clk_en    <= 1'b0;
            halt_code <= HALT_TIMEOUT;
          end else begin
            clk_en <= step_mode ? step_rise : 1'b1;
          end
        end

        HALT: begin
          // sys_rst_n is left alone so the halted system stays inspectable.
          if (start) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            sys_rst_n   <= 1'b0;
            clk_en      <= 1'b1;
            cycle_count <= '0;
            halt_code   <= HALT_NONE;
            halt_probe  <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller
//   Bench for run_controller with RESET_CYCLES=4, MAX_CYCLES=10, N_PROBES=4,
//   plus a second instance built with MAX_CYCLES=0 sharing the same inputs.
//   Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_run_controller;

  localparam int RESET_CYCLES = 4;
  localparam int MAX_CYCLES   = 10;
  localparam int N_PROBES     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  probe = 4'h0;

  logic        sys_rst_n, clk_en, running, halted;
  logic [1:0]  halt_code, halt_probe;
  logic [31:0] cycle_count;

  logic        sysRstN0, clkEn0, running0, halted0;
  logic [1:0]  haltCode0, haltProbe0;
  logic [31:0] cycleCount0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  run_controller #(
    .RESET_CYCLES (RESET_CYCLES),
    .MAX_CYCLES   (MAX_CYCLES),
    .CNT_W        (32),
    .N_PROBES     (N_PROBES)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .step_mode (step_mode),
    .step (step), .abort (abort), .probe (probe),
    .sys_rst_n (sys_rst_n), .clk_en (clk_en), .running (running),
    .halted (halted), .halt_code (halt_code), .halt_probe (halt_probe),
    .cycle_count (cycle_count)
  );

  run_controller #(
    .RESET_CYCLES (RESET_CYCLES),
    .MAX_CYCLES   (0),
    .CNT_W        (32),
    .N_PROBES     (N_PROBES)
  ) dutNoTimeout (
    .clk (clk), .rst_n (rst_n), .start (start), .step_mode (step_mode),
    .step (step), .abort (abort), .probe (probe),
    .sys_rst_n (sysRstN0), .clk_en (clkEn0), .running (running0),
    .halted (halted0), .halt_code (haltCode0), .halt_probe (haltProbe0),
    .cycle_count (cycleCount0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run and wait (bounded) for the main instance to reach RUN.
  task automatic startAndWaitRun(input string tag);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20 && !running; i++) tick();
    compared++; if (running !== 1'b1) begin mismatched++; $display("[TB] FAIL %s_reach_run: got %b want 1", tag, running); end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #20;
    compared++; if (sys_rst_n !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
    compared++; if (clk_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_clk_en: got %b want 0", clk_en); end
    compared++; if ({running, halted} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_run_halt: got %b want 00", {running, halted}); end
    compared++; if ({halt_code, halt_probe} !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_codes: got %h want 0", {halt_code, halt_probe}); end
    compared++; if (cycle_count !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", cycle_count); end
    rst_n = 1'b1;
    abort = 1'b1; tick(); tick(); abort = 1'b0;
    compared++; if ({running, halted, clk_en} !== 3'b000) begin mismatched++; $display("[TB] FAIL idle_ignores_abort: got %b want 000", {running, halted, clk_en}); end
  endtask

  task automatic test_timeout();
    int loCycles = 0;
    int hiCycles = 0;
    step_mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    compared++; if ({clk_en, sys_rst_n} !== 2'b10) begin mismatched++; $display("[TB] FAIL start_hold_outputs: got %b want 10", {clk_en, sys_rst_n}); end
    for (int i = 0; i < 100 && !halted; i++) begin
      if (clk_en) begin
        if (sys_rst_n) hiCycles++;
        else loCycles++;
      end
      tick();
    end
    compared++; if (halted !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_halted: got %b want 1", halted); end
    compared++; if (loCycles != RESET_CYCLES) begin mismatched++; $display("[TB] FAIL reset_hold_len: got %0d want %0d", loCycles, RESET_CYCLES); end
    compared++; if (hiCycles != MAX_CYCLES) begin mismatched++; $display("[TB] FAIL enabled_run_cycles: got %0d want %0d", hiCycles, MAX_CYCLES); end
    compared++; if (halt_code !== 2'd1) begin mismatched++; $display("[TB] FAIL timeout_code: got %0d want 1", halt_code); end
    compared++; if (cycle_count !== 32'(MAX_CYCLES)) begin mismatched++; $display("[TB] FAIL timeout_count: got %0d want %0d", cycle_count, MAX_CYCLES); end
    compared++; if ({clk_en, sys_rst_n} !== 2'b01) begin mismatched++; $display("[TB] FAIL halt_outputs: got %b want 01", {clk_en, sys_rst_n}); end
  endtask

  task automatic test_probe_halt(input int n, input logic [3:0] v);
    int lowBit;
    int expIdx;
    start = 1'b1; tick(); start = 1'b0;
    compared++; if ({cycle_count, halt_code, halt_probe} !== 36'd0) begin mismatched++; $display("[TB] FAIL restart_clears: got %0d/%0d/%0d want 0/0/0", cycle_count, halt_code, halt_probe); end
    for (int i = 0; i < 20 && !running; i++) tick();
    compared++; if (running !== 1'b1) begin mismatched++; $display("[TB] FAIL probe_reach_run: got %b want 1", running); end
    repeat (n - 1) tick();
    probe = v; tick(); probe = 4'h0;
    lowBit = int'(v) & -int'(v);
    expIdx = $clog2(lowBit);
    compared++; if ({halted, clk_en} !== 2'b10) begin mismatched++; $display("[TB] FAIL probe_halt_n%0d: got %b want 10", n, {halted, clk_en}); end
    compared++; if (halt_code !== 2'd2) begin mismatched++; $display("[TB] FAIL probe_code_n%0d: got %0d want 2", n, halt_code); end
    compared++; if (halt_probe !== 2'(expIdx)) begin mismatched++; $display("[TB] FAIL probe_index_v%b: got %0d want %0d", v, halt_probe, expIdx); end
    compared++; if (cycle_count !== 32'(n)) begin mismatched++; $display("[TB] FAIL probe_count: got %0d want %0d", cycle_count, n); end
    tick(); tick();
    compared++; if ({halt_code, cycle_count} !== {2'd2, 32'(n)}) begin mismatched++; $display("[TB] FAIL halt_frozen: got %0d/%0d want 2/%0d", halt_code, cycle_count, n); end
  endtask

  task automatic test_step_mode();
    bit seq[10] = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 0};
    bit prevStep;
    bit expEn;
    int pulses;
    step_mode = 1'b1; step = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    compared++; if ({clk_en, sys_rst_n} !== 2'b10) begin mismatched++; $display("[TB] FAIL step_hold_enable: got %b want 10", {clk_en, sys_rst_n}); end
    repeat (RESET_CYCLES - 1) tick();
    step = 1'b1; tick();
    compared++; if ({running, clk_en} !== 2'b11) begin mismatched++; $display("[TB] FAIL step_on_entry: got %b want 11", {running, clk_en}); end
    prevStep = 1'b1;
    pulses = 1;
    for (int i = 0; i < 10; i++) begin
      step = seq[i]; tick();
      expEn = seq[i] & ~prevStep;
      compared++; if (clk_en !== expEn) begin mismatched++; $display("[TB] FAIL step_pulse_%0d: got %b want %b", i, clk_en, expEn); end
      pulses += int'(expEn);
      prevStep = seq[i];
    end
    compared++; if (cycle_count !== 32'(pulses)) begin mismatched++; $display("[TB] FAIL step_count: got %0d want %0d", cycle_count, pulses); end
    compared++; if (running !== 1'b1) begin mismatched++; $display("[TB] FAIL step_still_running: got %b want 1", running); end
  endtask

  task automatic test_abort_probe();
    abort = 1'b1; probe = 4'b1000; tick(); probe = 4'h0;
    compared++; if ({halted, clk_en} !== 2'b10) begin mismatched++; $display("[TB] FAIL abort_halt: got %b want 10", {halted, clk_en}); end
    compared++; if (halt_code !== 2'd3) begin mismatched++; $display("[TB] FAIL abort_beats_probe: got %0d want 3", halt_code); end
    compared++; if (cycle_count !== 32'd3) begin mismatched++; $display("[TB] FAIL abort_count: got %0d want 3", cycle_count); end
    start = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    compared++; if ({running, halted, clk_en, sys_rst_n} !== 4'b0010) begin mismatched++; $display("[TB] FAIL start_beats_abort: got %b want 0010", {running, halted, clk_en, sys_rst_n}); end
    compared++; if ({cycle_count, halt_code, halt_probe} !== 36'd0) begin mismatched++; $display("[TB] FAIL start_clears_after_abort: got %0d/%0d/%0d want 0/0/0", cycle_count, halt_code, halt_probe); end
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    compared++; if ({halted, halt_code, clk_en, sys_rst_n} !== 5'b1_11_00) begin mismatched++; $display("[TB] FAIL abort_in_hold: got %b want 11100", {halted, halt_code, clk_en, sys_rst_n}); end
  endtask

  task automatic test_step_random();
    bit prevStep = 1'b0;
    bit s;
    bit expEn;
    int pulses = 0;
    step_mode = 1'b1; step = 1'b0;
    startAndWaitRun("rand_step");
    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom_range(0, 1));
      step = s; tick();
      expEn = s & ~prevStep;
      compared++; if (clk_en !== expEn) begin mismatched++; $display("[TB] FAIL rand_step_%0d: got %b want %b", i, clk_en, expEn); end
      pulses += int'(expEn);
      prevStep = s;
    end
    step = 1'b0; tick();
    compared++; if (cycle_count !== 32'(pulses)) begin mismatched++; $display("[TB] FAIL rand_step_count: got %0d want %0d", cycle_count, pulses); end
    abort = 1'b1; tick(); abort = 1'b0;
    compared++; if (halted !== 1'b1) begin mismatched++; $display("[TB] FAIL rand_step_abort: got %b want 1", halted); end
  endtask

  task automatic test_midrun_reset();
    step_mode = 1'b0;
    startAndWaitRun("midrun");
    repeat (6) tick();
    compared++; if (cycle_count !== 32'd6) begin mismatched++; $display("[TB] FAIL midrun_count: got %0d want 6", cycle_count); end
    #3 rst_n = 1'b0;
    #1;
    compared++; if ({sys_rst_n, clk_en, running, halted} !== 4'b0000) begin mismatched++; $display("[TB] FAIL async_reset_outputs: got %b want 0000", {sys_rst_n, clk_en, running, halted}); end
    compared++; if ({cycle_count, halt_code} !== 34'd0) begin mismatched++; $display("[TB] FAIL async_reset_count: got %0d/%0d want 0/0", cycle_count, halt_code); end
    #2 rst_n = 1'b1;
    probe = 4'hF;
    repeat (3) tick();
    probe = 4'h0;
    compared++; if ({running, halted, clk_en, halt_code} !== 5'd0) begin mismatched++; $display("[TB] FAIL idle_ignores_probe: got %b want 00000", {running, halted, clk_en, halt_code}); end
  endtask

  task automatic test_no_timeout();
    step_mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20 && !running0; i++) tick();
    compared++; if (running0 !== 1'b1) begin mismatched++; $display("[TB] FAIL notimeout_reach_run: got %b want 1", running0); end
    repeat (1000) tick();
    compared++; if ({running0, halted0, clkEn0, sysRstN0} !== 4'b1011) begin mismatched++; $display("[TB] FAIL notimeout_state: got %b want 1011", {running0, halted0, clkEn0, sysRstN0}); end
    compared++; if (cycleCount0 !== 32'd1000) begin mismatched++; $display("[TB] FAIL notimeout_count: got %0d want 1000", cycleCount0); end
    compared++; if ({haltCode0, haltProbe0} !== 4'h0) begin mismatched++; $display("[TB] FAIL notimeout_codes: got %h want 0", {haltCode0, haltProbe0}); end
    compared++; if ({halted, halt_code, cycle_count} !== {1'b1, 2'd1, 32'(MAX_CYCLES)}) begin mismatched++; $display("[TB] FAIL main_timeout_again: got %b/%0d/%0d want 1/1/%0d", halted, halt_code, cycle_count, MAX_CYCLES); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_timeout();
    test_probe_halt(5, 4'b0110);
    test_probe_halt(MAX_CYCLES, 4'($urandom_range(1, 15)));
    for (int k = 0; k < 4; k++) begin
      test_probe_halt(int'($urandom_range(1, MAX_CYCLES)), 4'($urandom_range(1, 15)));
    end
    test_step_mode();
    test_abort_probe();
    test_step_random();
    test_midrun_reset();
    test_no_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
